// File: rtl/elevator_pkg.sv
// Shared encodings and types for the elevator call panel.
package elevator_pkg;
  localparam logic [1:0] MODE_ADD    = 2'b00;
  localparam logic [1:0] MODE_LIST   = 2'b01;
  localparam logic [1:0] MODE_CANCEL = 2'b10;
  localparam logic [1:0] MODE_RUN    = 2'b11;

  localparam int CMD_FLOOR_W = 4;
  localparam logic [CMD_FLOOR_W-1:0] FLOOR_NONE = '0;
  // Controller pool holds at most 8 entries.
  localparam logic [3:0] LIST_MAX = 4'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_LIST} state_t;

  typedef struct packed {
    logic [1:0]             op;
    logic [CMD_FLOOR_W-1:0] floor;
  } cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO; push while full is accepted when a pop frees a slot the same edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/elevator_call_panel.sv
// Queues front-end commands and replays them as timed mode/request strobes to the controller.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int FLOOR_W = CMD_FLOOR_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [FLOOR_W-1:0] cmd_floor,
  output logic               cmd_ready,
  output logic               cmd_err,
  output logic [1:0]         mode,
  output logic [FLOOR_W-1:0] request,
  input  logic               elev_state,
  input  logic               elev_listBusy,
  input  logic [FLOOR_W-1:0] elev_listingLeds,
  output logic               list_valid,
  output logic [FLOOR_W-1:0] list_data,
  output logic               list_done,
  output logic [3:0]         list_count,
  output logic               busy
);
  state_t             state_q, state_d;
  cmd_t               push_cmd, head;
  logic               fifo_full, fifo_empty;
  logic               accept, floor_bad, push, pop;
  logic [1:0]         cmd_q_op;
  logic [FLOOR_W-1:0] cmd_q_floor;
  logic               first_cycle;
  logic [3:0]         list_cnt;

  assign push_cmd.op    = cmd_op;
  assign push_cmd.floor = cmd_floor;

  assign accept    = cmd_valid && cmd_ready;
  assign floor_bad = ((cmd_op == MODE_ADD) || (cmd_op == MODE_CANCEL)) && (cmd_floor == FLOOR_NONE);
  assign push      = accept && !floor_bad;
  // Controller only accepts commands while its cars are parked.
  assign pop       = (state_q == ST_IDLE) && !fifo_empty && !elev_state;

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .gclk   (CLK),
    .grst_n (RST_N),
    .push   (push),
    .pop    (pop),
    .din    (push_cmd),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mode    = MODE_ADD;
    request = '0;
    case (state_q)
      ST_IDLE: begin
        if (pop) state_d = (head.op == MODE_LIST) ? ST_LIST : ST_ISSUE;
      end
      ST_ISSUE: begin
        mode    = cmd_q_op;
        request = (cmd_q_op == MODE_RUN) ? '0 : cmd_q_floor;
        state_d = ST_IDLE;
      end
      ST_LIST: begin
        // Dropping to NOOP once listBusy falls keeps the controller from restarting its cursor.
        if (first_cycle || elev_listBusy) mode = MODE_LIST;
        if (!first_cycle && !elev_listBusy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_q_op    <= MODE_ADD;
      cmd_q_floor <= '0;
      first_cycle <= 1'b0;
      list_cnt    <= '0;
      cmd_err     <= 1'b0;
      list_valid  <= 1'b0;
      list_data   <= '0;
      list_done   <= 1'b0;
      list_count  <= '0;
    end else begin
      cmd_err    <= accept && floor_bad;
      list_valid <= 1'b0;
      list_done  <= 1'b0;
      if (pop) begin
        cmd_q_op    <= head.op;
        cmd_q_floor <= head.floor;
        first_cycle <= (head.op == MODE_LIST);
        list_cnt    <= '0;
      end
      if (state_q == ST_LIST) begin
        if (first_cycle) begin
          first_cycle <= 1'b0;
        end else if (elev_listBusy) begin
          list_valid <= 1'b1;
          list_data  <= elev_listingLeds;
          if (list_cnt != LIST_MAX) list_cnt <= list_cnt + 1'b1;
        end else begin
          list_done  <= 1'b1;
          list_count <= list_cnt;
        end
      end
    end
  end
endmodule
